// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared defaults for the push-button debouncer
//
// Purpose: holds the default channel count and qualification window so the
//          top and the per-channel block agree on them.
// Ports:   none (package).
package button_debouncer_pkg;

    // Three buttons feed the A, B, C inputs of the downstream AND gate.
    localparam int DEFAULT_NUM_CH          = 3;

    // 10 ms of stability at a 100 MHz system clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/button_debouncer_channel.sv
// rtl/button_debouncer_channel.sv - one-bit synchroniser, debounce counter and edge pulses
//
// Purpose: brings one raw pad input into the clk domain through a two-flop
//          synchroniser, accepts a new level only after DEBOUNCE_CYCLES
//          consecutive cycles of disagreement with the current level, and
//          emits a registered one-cycle pulse on each accepted transition.
// Ports:
//   clk      in  1  system clock, rising edge
//   rst_n    in  1  asynchronous active-low reset
//   i_raw    in  1  raw asynchronous input
//   o_level  out 1  debounced level
//   o_rise   out 1  one-cycle pulse on accepted 0->1
//   o_fall   out 1  one-cycle pulse on accepted 1->0
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    logic             w_differs;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_next;

    // Plain flop pair: nothing may sit between the two synchroniser stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where the synchronised input agrees with the accepted level
    // restarts the window; the counter stops at the accept point, so it
    // never wraps.
    always_comb begin
        w_differs  = (r_sync2 != r_stable);
        w_accept   = w_differs && (r_cnt == CNT_MAX);
        w_cnt_next = '0;
        if (w_differs && !w_accept) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            // Pulses land in the same cycle as the new level.
            r_rise <= w_accept &&  r_sync2;
            r_fall <= w_accept && !r_sync2;
            if (w_accept) begin
                r_stable <= r_sync2;
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel push-button debouncer feeding the AND gate
//
// Purpose: NUM_CH independent debounce channels; bits [2:0] of btn_level
//          drive gate inputs A, B, C.
// Ports:
//   clk        in  1       system clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   btn_raw    in  NUM_CH  raw pad inputs
//   btn_level  out NUM_CH  debounced levels
//   btn_rise   out NUM_CH  one-cycle pulse per channel on 0->1
//   btn_fall   out NUM_CH  one-cycle pulse per channel on 1->0
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_CH          = DEFAULT_NUM_CH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn_raw,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_rise,
    output logic [NUM_CH-1:0] btn_fall
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (btn_raw[g]),
            .o_level (btn_level[g]),
            .o_rise  (btn_rise[g]),
            .o_fall  (btn_fall[g])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;
    logic [2:0] btn_fall;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .NUM_CH          (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] lvl,
                           input logic [2:0] rise, input logic [2:0] fall);
        chk({tag, ".level"}, btn_level, lvl);
        chk({tag, ".rise"},  btn_rise,  rise);
        chk({tag, ".fall"},  btn_fall,  fall);
    endtask

    initial begin
        // Reset held with all inputs high.
        rst_n   = 1'b0;
        btn_raw = 3'b111;
        #1;
        chk_all("reset_async", 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("reset_hold", 3'b000, 3'b000, 3'b000);
        end
        rst_n = 1'b1;
        ticks(5);
        chk_all("release_e5", 3'b000, 3'b000, 3'b000);
        tick();
        chk_all("release_e6", 3'b111, 3'b111, 3'b000);
        tick();
        chk_all("release_e7", 3'b111, 3'b000, 3'b000);

        // All inputs fall back to 0.
        btn_raw = 3'b000;
        ticks(5);
        chk_all("fall_e5", 3'b111, 3'b000, 3'b000);
        tick();
        chk_all("fall_e6", 3'b000, 3'b000, 3'b111);
        tick();
        chk_all("fall_e7", 3'b000, 3'b000, 3'b000);

        // Clean step on channel 0.
        btn_raw = 3'b001;
        ticks(5);
        chk_all("step_e4", 3'b000, 3'b000, 3'b000);
        tick();
        chk_all("step_e5", 3'b001, 3'b001, 3'b000);
        tick();
        chk_all("step_e6", 3'b001, 3'b000, 3'b000);

        // Bounce on channel 1: 1,0,1,0,1,0 two cycles each, then hold 1.
        for (int s = 0; s < 6; s++) begin
            btn_raw[1] = (s % 2 == 0);
            for (int c = 0; c < 2; c++) begin
                tick();
                chk_all("bounce", 3'b001, 3'b000, 3'b000);
            end
        end
        btn_raw[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("bounce_hold", 3'b001, 3'b000, 3'b000);
        end
        tick();
        chk_all("bounce_accept", 3'b011, 3'b010, 3'b000);
        tick();
        chk_all("bounce_after", 3'b011, 3'b000, 3'b000);

        // 3-cycle pulse on channel 2 is rejected.
        btn_raw[2] = 1'b1;
        ticks(3);
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("glitch3", 3'b011, 3'b000, 3'b000);
        end

        // 4-cycle pulse on channel 2 is accepted, then released 4 cycles later.
        btn_raw[2] = 1'b1;
        ticks(4);
        btn_raw[2] = 1'b0;
        tick();
        chk_all("glitch4_e4", 3'b011, 3'b000, 3'b000);
        tick();
        chk_all("glitch4_rise", 3'b111, 3'b100, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("glitch4_high", 3'b111, 3'b000, 3'b000);
        end
        tick();
        chk_all("glitch4_fall", 3'b011, 3'b000, 3'b100);
        tick();
        chk_all("glitch4_after", 3'b011, 3'b000, 3'b000);

        // Channel 2 counts to 2, then reset drops between edges.
        btn_raw = 3'b111;
        ticks(4);
        chk_all("midcount", 3'b011, 3'b000, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midcount_reset", 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("restart_wait", 3'b000, 3'b000, 3'b000);
        end
        tick();
        chk_all("restart_e6", 3'b111, 3'b111, 3'b000);

        // Return to 000, then simultaneous 000->101.
        btn_raw = 3'b000;
        ticks(6);
        chk_all("clear", 3'b000, 3'b000, 3'b111);
        ticks(2);
        btn_raw = 3'b101;
        ticks(5);
        chk_all("simul_e4", 3'b000, 3'b000, 3'b000);
        tick();
        chk_all("simul_e5", 3'b101, 3'b101, 3'b000);
        tick();
        chk_all("simul_e6", 3'b101, 3'b000, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
